// File: rtl/xadc_aux_scanner.sv
`default_nettype none
// ============================================================================
// Module   : xadc_aux_scanner
// Brief    : Scans a block of XADC auxiliary channels over the DRP port on
//            each end-of-sequence pulse, averages 2**AVG_LOG2 readings per
//            channel and raises a per-channel high-threshold alarm.
// Revision : 1.0 - initial release
// ============================================================================
module xadc_aux_scanner #(
    parameter int NUM_CH   = 4,
    parameter int BASE_CH  = 0,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 63
) (
    input  logic                   DCLK,
    input  logic                   RESET,
    input  logic                   EOS,
    input  logic [15:0]            THRESH_HI,
    output logic                   DEN,
    output logic                   DWE,
    output logic [6:0]             DADDR,
    output logic [15:0]            DI,
    input  logic [15:0]            DO,
    input  logic                   DRDY,
    output logic [NUM_CH*16-1:0]   MEASURED_AUX,
    output logic [NUM_CH-1:0]      SAMPLE_VALID,
    output logic [NUM_CH-1:0]      ALM_HI,
    output logic                   SCAN_DONE,
    output logic                   TIMEOUT_ERR
);

    localparam int         c_ACC_W = 12 + AVG_LOG2;
    localparam int         c_CNT_W = AVG_LOG2 + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(1 << AVG_LOG2);
    localparam logic [6:0] c_ADDR0 = 7'(16 + BASE_CH);
    localparam logic [7:0] c_TMO   = 8'(TIMEOUT);
    localparam logic [3:0] c_LAST  = 4'(NUM_CH - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_NEXT = 2'd3;

    logic [1:0]          r_state;
    logic [3:0]          r_idx;
    logic [7:0]          r_tmr;
    logic [c_ACC_W-1:0]  r_acc  [NUM_CH];
    logic [c_CNT_W-1:0]  r_cnt  [NUM_CH];
    logic [15:0]         r_meas [NUM_CH];
    logic [NUM_CH-1:0]   r_valid;
    logic [NUM_CH-1:0]   r_alm;
    logic                r_done;
    logic                r_terr;
    logic                r_den;
    logic [6:0]          r_daddr;

    logic [c_ACC_W-1:0]  w_acc_cur;
    logic [c_CNT_W-1:0]  w_cnt_cur;
    logic [c_ACC_W-1:0]  w_sum;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                w_full;
    logic [11:0]         w_avg;
    logic                w_alarm;
    logic                w_last;
    logic                w_unused_bits;

    // Select the accumulator and sample count of the channel being read
    always_comb begin
        w_acc_cur = '0;
        w_cnt_cur = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_idx == 4'(k)) begin
                w_acc_cur = r_acc[k];
                w_cnt_cur = r_cnt[k];
            end
        end
    end

    // The sum can never exceed 2**AVG_LOG2 * 4095, so c_ACC_W bits suffice
    assign w_sum         = w_acc_cur + c_ACC_W'(DO[15:4]);
    assign w_cnt_nxt     = w_cnt_cur + c_CNT_W'(1);
    assign w_full        = (w_cnt_nxt == c_FULL);
    assign w_avg         = 12'(w_sum >> AVG_LOG2);
    assign w_alarm       = (w_avg >= THRESH_HI[15:4]);
    assign w_last        = (r_idx == c_LAST);
    // Low nibbles of the ADC format carry no information here
    assign w_unused_bits = ^{DO[3:0], THRESH_HI[3:0]};

    // Scan sequencer, DRP handshake, averaging and result registers
    always_ff @(posedge DCLK) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_tmr   <= '0;
            r_valid <= '0;
            r_alm   <= '0;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
            r_den   <= 1'b0;
            r_daddr <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_acc[k]  <= '0;
                r_cnt[k]  <= '0;
                r_meas[k] <= '0;
            end
        end else begin
            r_den   <= 1'b0;
            r_valid <= '0;
            r_done  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (EOS) begin
                        r_state <= c_ST_REQ;
                        r_idx   <= '0;
                        r_den   <= 1'b1;
                        r_daddr <= c_ADDR0;
                    end
                end
                c_ST_REQ: begin
                    r_state <= c_ST_WAIT;
                    r_tmr   <= '0;
                end
                c_ST_WAIT: begin
                    // DRDY wins over an expiring counter in the same cycle
                    if (DRDY) begin
                        r_state <= c_ST_NEXT;
                        r_done  <= w_last;
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (r_idx == 4'(k)) begin
                                if (w_full) begin
                                    r_acc[k]   <= '0;
                                    r_cnt[k]   <= '0;
                                    r_meas[k]  <= {w_avg, 4'b0000};
                                    r_valid[k] <= 1'b1;
                                    r_alm[k]   <= w_alarm;
                                end else begin
                                    r_acc[k] <= w_sum;
                                    r_cnt[k] <= w_cnt_nxt;
                                end
                            end
                        end
                    end else if (r_tmr == c_TMO) begin
                        r_state <= c_ST_NEXT;
                        r_terr  <= 1'b1;
                        r_done  <= w_last;
                    end else begin
                        r_tmr <= r_tmr + 8'd1;
                    end
                end
                c_ST_NEXT: begin
                    if (!w_last) begin
                        r_state <= c_ST_REQ;
                        r_idx   <= r_idx + 4'd1;
                        r_den   <= 1'b1;
                        r_daddr <= c_ADDR0 + 7'(r_idx + 4'd1);
                    end else begin
                        r_state <= c_ST_IDLE;
                        r_idx   <= '0;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Flatten the per-channel result registers onto the output bus
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_meas_out
            assign MEASURED_AUX[16*g +: 16] = r_meas[g];
        end
    endgenerate

    assign DEN          = r_den;
    assign DWE          = 1'b0;
    assign DADDR        = r_daddr;
    assign DI           = 16'h0000;
    assign SAMPLE_VALID = r_valid;
    assign ALM_HI       = r_alm;
    assign SCAN_DONE    = r_done;
    assign TIMEOUT_ERR  = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_xadc_aux_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_xadc_aux_scanner
// Brief    : Randomised DRP-responder bench for xadc_aux_scanner with a
//            per-channel running-average reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xadc_aux_scanner;

    localparam int NUM_CH   = 4;
    localparam int BASE_CH  = 0;
    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 63;
    localparam int NAVG     = 1 << AVG_LOG2;

    logic                 clk = 1'b0;
    logic                 r_rst;
    logic                 r_eos;
    logic [15:0]          r_thresh;
    logic [15:0]          r_do;
    logic                 r_drdy;
    logic                 w_den;
    logic                 w_dwe;
    logic [6:0]           w_daddr;
    logic [15:0]          w_di;
    logic [NUM_CH*16-1:0] w_measured;
    logic [NUM_CH-1:0]    w_sample_valid;
    logic [NUM_CH-1:0]    w_alm_hi;
    logic                 w_scan_done;
    logic                 w_timeout_err;

    xadc_aux_scanner #(
        .NUM_CH   (NUM_CH),
        .BASE_CH  (BASE_CH),
        .AVG_LOG2 (AVG_LOG2),
        .TIMEOUT  (TIMEOUT)
    ) u_dut (
        .DCLK         (clk),
        .RESET        (r_rst),
        .EOS          (r_eos),
        .THRESH_HI    (r_thresh),
        .DEN          (w_den),
        .DWE          (w_dwe),
        .DADDR        (w_daddr),
        .DI           (w_di),
        .DO           (r_do),
        .DRDY         (r_drdy),
        .MEASURED_AUX (w_measured),
        .SAMPLE_VALID (w_sample_valid),
        .ALM_HI       (w_alm_hi),
        .SCAN_DONE    (w_scan_done),
        .TIMEOUT_ERR  (w_timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int sv_cnt   = 0;
    int sv0_cnt  = 0;

    // Reference model: plain running sums per channel
    int                sum_m [NUM_CH];
    int                n_m   [NUM_CH];
    logic [15:0]       exp_meas [NUM_CH];
    logic [NUM_CH-1:0] exp_alm;
    logic              exp_terr;

    // Per-scan stimulus: read data, DRDY delay (-1 = withhold), EOS during WAIT
    logic [15:0] s_do  [NUM_CH];
    int          s_dly [NUM_CH];
    logic        s_eos [NUM_CH];

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters for pulse outputs
    always @(negedge clk) begin
        if (w_scan_done) done_cnt++;
        if (w_sample_valid != '0) sv_cnt++;
        if (w_sample_valid[0]) sv0_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NUM_CH*16-1:0] pack_meas();
        pack_meas = '0;
        for (int k = 0; k < NUM_CH; k++) pack_meas[k*16 +: 16] = exp_meas[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            sum_m[k] = 0;
            n_m[k] = 0;
            exp_meas[k] = 16'h0000;
        end
        exp_alm  = '0;
        exp_terr = 1'b0;
    endtask

    task automatic model_accept(input int k, input logic [15:0] d, output logic [NUM_CH-1:0] sv);
        int avg;
        sv = '0;
        sum_m[k] += int'(d[15:4]);
        n_m[k]++;
        if (n_m[k] == NAVG) begin
            avg = sum_m[k] / NAVG;
            exp_meas[k] = 16'(avg * 16);
            exp_alm[k]  = (avg >= int'(r_thresh[15:4]));
            sum_m[k] = 0;
            n_m[k]   = 0;
            sv[k]    = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_meas"}, w_measured, pack_meas());
        check({tag, "_alm"},  w_alm_hi, exp_alm);
        check({tag, "_terr"}, w_timeout_err, exp_terr);
    endtask

    // One full scan, acting as the DRP slave with the s_* stimulus
    task automatic run_scan();
        int eos_cyc, total, wcyc, d0, got_den;
        logic [NUM_CH-1:0] exp_sv;
        d0 = done_cnt;
        @(negedge clk);
        r_eos   = 1'b1;
        eos_cyc = cyc;
        @(negedge clk);
        r_eos = 1'b0;
        total = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            got_den = 0;
            for (int t = 0; t < 8 && got_den == 0; t++) begin
                if (w_den) got_den = 1;
                else @(negedge clk);
            end
            check("den_seen", 64'(got_den), 64'd1);
            if (got_den == 0) return;
            check("den_time", 64'(cyc - eos_cyc), 64'(1 + total));
            check("daddr", 64'(w_daddr), 64'(16 + BASE_CH + k));
            @(negedge clk);
            check("den_one_cycle", 64'(w_den), 64'd0);
            wcyc = (s_dly[k] < 0) ? TIMEOUT : s_dly[k];
            repeat (wcyc) @(negedge clk);
            if (s_eos[k]) r_eos = 1'b1;
            if (s_dly[k] >= 0) begin
                r_drdy = 1'b1;
                r_do   = s_do[k];
            end
            @(negedge clk);
            r_drdy = 1'b0;
            r_eos  = 1'b0;
            r_do   = 16'($urandom);
            exp_sv = '0;
            if (s_dly[k] >= 0) model_accept(k, s_do[k], exp_sv);
            else exp_terr = 1'b1;
            check("sample_valid", 64'(w_sample_valid), 64'(exp_sv));
            check("scan_done", 64'(w_scan_done), 64'(k == NUM_CH - 1));
            check_outputs("chan");
            total += wcyc + 3;
            @(negedge clk);
        end
        @(negedge clk);
        check("scan_done_count", 64'(done_cnt - d0), 64'd1);
        check("idle_den", 64'(w_den), 64'd0);
    endtask

    task automatic fill_scan(input logic [15:0] d, input int max_dly);
        for (int k = 0; k < NUM_CH; k++) begin
            s_do[k]  = d;
            s_dly[k] = $urandom_range(0, max_dly);
            s_eos[k] = 1'b0;
        end
    endtask

    initial begin
        int r, sv_before;
        r_rst = 1'b1; r_eos = 1'b0; r_thresh = 16'h0000; r_do = 16'h0000; r_drdy = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        r_rst = 1'b0;
        @(negedge clk);
        check("rst_den", 64'(w_den), 64'd0);
        check("rst_daddr", 64'(w_daddr), 64'd0);
        check("rst_dwe", 64'(w_dwe), 64'd0);
        check("rst_di", 64'(w_di), 64'd0);
        check("rst_sv", 64'(w_sample_valid), 64'd0);
        check("rst_done", 64'(w_scan_done), 64'd0);
        check_outputs("rst");

        // Four-sample average on ch0: 0x10,0x20,0x30,0x34 -> 0x25
        r_thresh = 16'h0000;
        for (int s = 0; s < 4; s++) begin
            fill_scan(16'($urandom) & 16'hFFF0, 4);
            s_do[0] = (s == 0) ? 16'h0100 : (s == 1) ? 16'h0200 : (s == 2) ? 16'h0300 : 16'h0340;
            s_eos[1] = 1'b1;
            run_scan();
        end
        check("avg_ch0", 64'(w_measured[15:0]), 64'h0250);
        check("sv0_once", 64'(sv0_cnt), 64'd1);

        // Alarm threshold boundary: average 0x7FF below, 0x800 at threshold
        r_thresh = 16'h8000;
        for (int s = 0; s < NAVG; s++) begin
            fill_scan(16'h7FF0, 3);
            run_scan();
        end
        check("alm_below", 64'(w_alm_hi), 64'h0);
        for (int s = 0; s < NAVG; s++) begin
            fill_scan(16'h8000, 3);
            run_scan();
        end
        check("alm_at", 64'(w_alm_hi), 64'hF);

        // Withheld DRDY on ch1, and DRDY on the last permitted wait cycle on ch2
        fill_scan(16'h1230, 2);
        s_dly[1] = -1;
        s_dly[2] = TIMEOUT;
        run_scan();
        check("terr_set", 64'(w_timeout_err), 64'd1);

        // Randomised scans
        for (int s = 0; s < 14; s++) begin
            r_thresh = 16'($urandom);
            for (int k = 0; k < NUM_CH; k++) begin
                s_do[k] = 16'($urandom);
                r = $urandom_range(0, 11);
                s_dly[k] = (r < 8) ? (r % 5) : (r == 8) ? TIMEOUT : (r == 9) ? -1 : TIMEOUT - 1;
                s_eos[k] = 1'($urandom);
            end
            run_scan();
        end

        // DRDY while idle is ignored
        sv_before = sv_cnt;
        @(negedge clk);
        r_drdy = 1'b1; r_do = 16'hFFF0;
        @(negedge clk);
        r_drdy = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_drdy_sv", 64'(sv_cnt - sv_before), 64'd0);
        check_outputs("idle_drdy");

        // Reset beats EOS in the same cycle
        r_rst = 1'b1; r_eos = 1'b1;
        @(negedge clk);
        r_rst = 1'b0; r_eos = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("rst_eos_den", 64'(w_den), 64'd0);
        end

        // Build up state, then reset mid-WAIT and return a late DRDY
        fill_scan(16'hABC0, 2);
        for (int s = 0; s < NAVG; s++) run_scan();
        check("pre_rst_meas", 64'(w_measured), 64'hABC0ABC0ABC0ABC0);
        @(negedge clk); r_eos = 1'b1;
        @(negedge clk); r_eos = 1'b0;
        @(negedge clk);
        @(negedge clk); r_rst = 1'b1;
        @(negedge clk); r_rst = 1'b0; r_drdy = 1'b1; r_do = 16'hFFF0;
        model_reset();
        sv_before = sv_cnt;
        @(negedge clk); r_drdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_den", 64'(w_den), 64'd0);
        end
        check("post_rst_daddr", 64'(w_daddr), 64'd0);
        check("post_rst_sv", 64'(sv_cnt - sv_before), 64'd0);
        check_outputs("post_rst");

        // Scanner is usable again after reset
        fill_scan(16'h5550, 4);
        run_scan();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
